// File: rtl/dual_port_ram.sv
// Single-clock BRAM with a read/write CPU port (A), a read-only port (B),
// and a post-reset clear sweep that owns the write port until it finishes.
module dual_port_ram #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    READ_MODE      = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic                  write_enable_a,
    input  logic                  read_enable_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic                  valid_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  read_enable_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    output logic                  valid_b
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    ready;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   storage [DEPTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        else
            state <= next_state;
    end

    // Next-state logic: sweep ends once the last word has been written
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (&clear_addr) next_state = READY;
            READY:   next_state = READY;
            default: next_state = READY;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        case (state)
            CLEAR:   busy  = 1'b1;
            READY:   ready = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    // Wraps to 0 after DEPTH-1, leaving it ready for the next reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clear_addr <= '0;
        else if (busy)
            clear_addr <= clear_addr + 1'b1;
    end

    // Single write port shared by the sweep and port A
    always_comb begin
        wr_en   = busy | (ready & write_enable_a);
        wr_addr = busy ? clear_addr  : address_a;
        wr_data = busy ? CLEAR_VALUE : data_in_a;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            storage[wr_addr] <= wr_data;
    end

    // Port A: reads sample pre-write contents, so read-first falls out naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_a <= '0;
            valid_a    <= 1'b0;
        end else begin
            valid_a <= ready & (write_enable_a | read_enable_a);
            if (ready & write_enable_a)
                data_out_a <= (READ_MODE == 1) ? data_in_a : storage[address_a];
            else if (ready & read_enable_a)
                data_out_a <= storage[address_a];
        end
    end

    // Port B always sees old contents on a same-address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_b <= '0;
            valid_b    <= 1'b0;
        end else begin
            valid_b <= ready & read_enable_b;
            if (ready & read_enable_b)
                data_out_b <= storage[address_b];
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: read-first, write-first and no-clear
// instances share stimulus; each scenario task checks its own results.
module tb_dual_port_ram;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, reset_nc;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_in_a;
    logic          write_enable_a, read_enable_a, read_enable_b;

    logic          busy0, busy1, busy2;
    logic [DW-1:0] data_out_a0, data_out_a1, data_out_a2;
    logic [DW-1:0] data_out_b0, data_out_b1, data_out_b2;
    logic          valid_a0, valid_a1, valid_a2;
    logic          valid_b0, valid_b1, valid_b2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0),
                    .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) dut_rf (
        .clk(clk), .reset(reset), .busy(busy0),
        .address_a(address_a), .data_in_a(data_in_a),
        .write_enable_a(write_enable_a), .read_enable_a(read_enable_a),
        .data_out_a(data_out_a0), .valid_a(valid_a0),
        .address_b(address_b), .read_enable_b(read_enable_b),
        .data_out_b(data_out_b0), .valid_b(valid_b0));

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(1),
                    .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) dut_wf (
        .clk(clk), .reset(reset), .busy(busy1),
        .address_a(address_a), .data_in_a(data_in_a),
        .write_enable_a(write_enable_a), .read_enable_a(read_enable_a),
        .data_out_a(data_out_a1), .valid_a(valid_a1),
        .address_b(address_b), .read_enable_b(read_enable_b),
        .data_out_b(data_out_b1), .valid_b(valid_b1));

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0),
                    .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'hA5)) dut_nc (
        .clk(clk), .reset(reset_nc), .busy(busy2),
        .address_a(address_a), .data_in_a(data_in_a),
        .write_enable_a(write_enable_a), .read_enable_a(read_enable_a),
        .data_out_a(data_out_a2), .valid_a(valid_a2),
        .address_b(address_b), .read_enable_b(read_enable_b),
        .data_out_b(data_out_b2), .valid_b(valid_b2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable_a = 1'b0;
        read_enable_a  = 1'b0;
        read_enable_b  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_nc = 1'b1;
        idle(); address_a = '0; address_b = '0; data_in_a = '0;
        step(); step();
        total++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) $display("FAIL reset_busy: got %b/%b need 1/1", busy0, busy1);
        else passed++;
        total++;
        if (busy2 !== 1'b0) $display("FAIL reset_busy_noclear: got %b need 0", busy2);
        else passed++;
        total++;
        if (data_out_a0 !== 8'h00 || data_out_b0 !== 8'h00 || valid_a0 !== 1'b0 || valid_b0 !== 1'b0)
            $display("FAIL reset_outputs: got da=%h db=%h va=%b vb=%b need 00 00 0 0",
                     data_out_a0, data_out_b0, valid_a0, valid_b0);
        else passed++;
    endtask

    // Holds a port-A write of FF to addr 2 plus reads during the whole sweep
    task automatic test_sweep();
        int  cycles = 0;
        bit  stray_valid = 1'b0;
        address_a = 4'd2; data_in_a = 8'hFF; write_enable_a = 1'b1;
        read_enable_a = 1'b1; read_enable_b = 1'b1; address_b = 4'd2;
        reset = 1'b0;
        while (busy0 === 1'b1 && cycles < 40) begin
            step();
            cycles++;
            if (busy0 === 1'b1 && (valid_a0 !== 1'b0 || valid_b0 !== 1'b0)) stray_valid = 1'b1;
        end
        idle();
        total++;
        if (cycles != 16) $display("FAIL sweep_busy_cycles: got %0d need 16", cycles);
        else passed++;
        total++;
        if (stray_valid) $display("FAIL sweep_valid_gated: got valid during busy need none");
        else passed++;
        total++;
        if (data_out_a0 !== 8'h00) $display("FAIL sweep_data_hold: got %h need 00", data_out_a0);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            address_b = AW'(i); read_enable_b = 1'b1;
            step();
            total++;
            if (data_out_b0 !== 8'hA5 || valid_b0 !== 1'b1)
                $display("FAIL sweep_readback[%0d]: got %h v=%b need a5 v=1", i, data_out_b0, valid_b0);
            else passed++;
        end
        idle();
    endtask

    task automatic test_basic();
        address_a = 4'd5; data_in_a = 8'h3C; write_enable_a = 1'b1;
        step();
        total++;
        if (valid_a0 !== 1'b1) $display("FAIL basic_write_valid: got %b need 1", valid_a0);
        else passed++;
        write_enable_a = 1'b0; read_enable_a = 1'b1;
        step();
        total++;
        if (data_out_a0 !== 8'h3C || valid_a0 !== 1'b1)
            $display("FAIL basic_read: got %h v=%b need 3c v=1", data_out_a0, valid_a0);
        else passed++;
        idle();
        step();
        total++;
        if (data_out_a0 !== 8'h3C || valid_a0 !== 1'b0)
            $display("FAIL basic_idle_hold: got %h v=%b need 3c v=0", data_out_a0, valid_a0);
        else passed++;
    endtask

    task automatic test_read_mode();
        address_a = 4'd7; data_in_a = 8'h11; write_enable_a = 1'b1;
        step();
        data_in_a = 8'h22;
        step();
        total++;
        if (data_out_a0 !== 8'h11) $display("FAIL read_first: got %h need 11", data_out_a0);
        else passed++;
        total++;
        if (data_out_a1 !== 8'h22 || valid_a1 !== 1'b1)
            $display("FAIL write_first: got %h v=%b need 22 v=1", data_out_a1, valid_a1);
        else passed++;
        write_enable_a = 1'b0; read_enable_a = 1'b1;
        step();
        total++;
        if (data_out_a0 !== 8'h22 || data_out_a1 !== 8'h22)
            $display("FAIL read_mode_followup: got %h/%h need 22/22", data_out_a0, data_out_a1);
        else passed++;
        idle();
    endtask

    task automatic test_collision();
        address_a = 4'd3; data_in_a = 8'h00; write_enable_a = 1'b1;
        step();
        data_in_a = 8'h99; address_b = 4'd3; read_enable_b = 1'b1;
        step();
        total++;
        if (data_out_b0 !== 8'h00 || data_out_b1 !== 8'h00 || valid_b0 !== 1'b1)
            $display("FAIL collision_old: got %h/%h v=%b need 00/00 v=1", data_out_b0, data_out_b1, valid_b0);
        else passed++;
        write_enable_a = 1'b0;
        step();
        total++;
        if (data_out_b0 !== 8'h99 || valid_b0 !== 1'b1)
            $display("FAIL collision_new: got %h v=%b need 99 v=1", data_out_b0, valid_b0);
        else passed++;
        idle();
        step();
        total++;
        if (valid_b0 !== 1'b0 || data_out_b0 !== 8'h99)
            $display("FAIL port_b_idle_hold: got %h v=%b need 99 v=0", data_out_b0, valid_b0);
        else passed++;
    endtask

    task automatic test_mid_sweep_reset();
        int cycles = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (9) step();
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy0 !== 1'b1 || valid_a0 !== 1'b0 || data_out_a0 !== 8'h00)
            $display("FAIL mid_reset_async: got busy=%b va=%b da=%h need 1 0 00", busy0, valid_a0, data_out_a0);
        else passed++;
        step();
        reset = 1'b0;
        while (busy0 === 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        total++;
        if (cycles != 16) $display("FAIL mid_reset_full_sweep: got %0d need 16", cycles);
        else passed++;
        address_b = 4'd15; read_enable_b = 1'b1;
        step();
        total++;
        if (data_out_b0 !== 8'hA5) $display("FAIL mid_reset_last_word: got %h need a5", data_out_b0);
        else passed++;
        idle();
    endtask

    task automatic test_no_clear();
        reset_nc = 1'b0;
        address_a = 4'd9; data_in_a = 8'h5A; write_enable_a = 1'b1;
        total++;
        if (busy2 !== 1'b0) $display("FAIL noclear_busy: got %b need 0", busy2);
        else passed++;
        step();
        total++;
        if (valid_a2 !== 1'b1) $display("FAIL noclear_write_valid: got %b need 1", valid_a2);
        else passed++;
        write_enable_a = 1'b0; read_enable_a = 1'b1;
        step();
        total++;
        if (data_out_a2 !== 8'h5A || valid_a2 !== 1'b1)
            $display("FAIL noclear_read: got %h v=%b need 5a v=1", data_out_a2, valid_a2);
        else passed++;
        idle();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_basic();
        test_read_mode();
        test_collision();
        test_mid_sweep_reset();
        test_no_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
